vvrf_readback_serializer: RTL and testbench

- Reader side of the vector-vector register file (vvrf) that the vector ALU writes through its cache port.
- On a start command it reads a run of N-lane vectors from the RAM's read port. It serializes each vector lane by lane onto a DATA_WIDTH valid/ready stream toward the host trace drain.
- It lets firmware dump cached ALU state without stopping tracing.

---
 rtl/vvrf_readback_serializer_pkg.sv | 35 +++
 rtl/vvrf_readback_serializer_if.sv | 23 ++
 rtl/vvrf_readback_serializer.sv | 117 +++++++++++
 tb/tb_vvrf_readback_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvrf_readback_serializer_pkg.sv
// Shared types and helpers for the vvrf readback serializer.
package vvrf_readback_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SHIFT,
        FINISH
    } vvrf_rb_state_t;

    // Default vvrf geometry, matching the ALU cache port.
    localparam int VVRF_N          = 8;
    localparam int VVRF_DATA_WIDTH = 32;
    localparam int VVRF_MEM_W      = VVRF_N * VVRF_DATA_WIDTH;

    // Address width of a vvrf with `size` entries (at least one bit).
    function automatic int calc_addr_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Packed width of one N-lane vector.
    function automatic int calc_mem_width(input int n, input int dw);
        return n * dw;
    endfunction

    // Lane idx of a packed vector; lane 0 lives in the most significant lane slot.
    function automatic logic [VVRF_DATA_WIDTH-1:0] get_lane(
        input logic [VVRF_MEM_W-1:0] vec,
        input int                    idx
    );
        return vec[VVRF_MEM_W-1-idx*VVRF_DATA_WIDTH -: VVRF_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/vvrf_readback_serializer_if.sv
// Valid/ready lane stream from the serializer toward the host trace drain.
interface vvrf_readback_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/vvrf_readback_serializer.sv
// Reads a run of vectors from the vvrf read port and streams them lane by lane.
module vvrf_readback_serializer
    import vvrf_readback_serializer_pkg::*;
#(
    parameter int  N           = 8,
    parameter int  DATA_WIDTH  = 32,
    parameter int  VVVRF_SIZE  = 8,
    parameter int  RAM_LATENCY = 1,
    localparam int ADDR_W      = calc_addr_w(VVVRF_SIZE),
    localparam int MEM_WIDTH   = calc_mem_width(N, DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [ADDR_W:0]      num_vectors,
    output logic [ADDR_W-1:0]    mem_address,
    input  logic [MEM_WIDTH-1:0] mem_data,
    vvrf_readback_serializer_if.master out_if,
    output logic                 busy,
    output logic                 done
);

    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    // The wait counter holds RAM_LATENCY-1 down to 0.
    localparam int WAIT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RAM_LATENCY - 1);
    localparam logic [ADDR_W:0]   ONE_VEC   = (ADDR_W + 1)'(1);

    vvrf_rb_state_t        state;
    logic [MEM_WIDTH-1:0]  shreg;
    logic [LANE_W-1:0]     lane;
    logic [ADDR_W:0]       remaining;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  out_valid_q;
    logic                  fire;

    assign fire             = out_valid_q && out_if.out_ready;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = shreg[MEM_WIDTH-1 -: DATA_WIDTH];
    // Derived only from registers, so it holds steady while a beat is stalled.
    assign out_if.out_last  = out_valid_q && (lane == LAST_LANE) && (remaining == ONE_VEC);
    assign busy             = (state != IDLE);

    // Control FSM, address/count tracking and the lane shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_address <= '0;
            shreg       <= '0;
            lane        <= '0;
            remaining   <= '0;
            wait_cnt    <= '0;
            out_valid_q <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_vectors == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            remaining   <= num_vectors;
                            mem_address <= start_addr;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        shreg       <= mem_data;
                        lane        <= '0;
                        out_valid_q <= 1'b1;
                        state       <= SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (fire) begin
                        shreg <= shreg << DATA_WIDTH;
                        if (lane == LAST_LANE) begin
                            lane        <= '0;
                            out_valid_q <= 1'b0;
                            if (remaining > ONE_VEC) begin
                                // Address wraps naturally: VVVRF_SIZE is a power of two.
                                mem_address <= mem_address + 1'b1;
                                remaining   <= remaining - 1'b1;
                                state       <= ISSUE;
                            end else begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vvrf_readback_serializer.sv
// Directed scoreboard bench for the vvrf readback serializer.
module tb_vvrf_readback_serializer;
    import vvrf_readback_serializer_pkg::*;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int SZ = 8;
    localparam int RL = 1;
    localparam int AW = 3;
    localparam int MW = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   num_vectors = '0;
    logic [AW-1:0] mem_address;
    logic [MW-1:0] mem_data;
    logic          busy;
    logic          done;

    vvrf_readback_serializer_if #(.DATA_WIDTH(DW)) out_if ();

    vvrf_readback_serializer #(
        .N(N), .DATA_WIDTH(DW), .VVVRF_SIZE(SZ), .RAM_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .num_vectors(num_vectors), .mem_address(mem_address), .mem_data(mem_data),
        .out_if(out_if.master), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // vvrf model with a one-cycle registered read port.
    logic [MW-1:0] vvrf [SZ];
    always @(posedge clk) mem_data <= vvrf[mem_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [AW-1:0] addr;
        int            gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;
    int   last_cnt = 0;
    int   done_cnt = 0;
    int   last_hs_cyc = 0;
    int   last_done_cyc = 0;
    int   first_valid_cyc = 0;
    bit   seen_valid = 1'b0;
    bit   rand_ready = 1'b0;
    int   t_start = 0;

    // Lane l of vvrf[a]: vvrf[2] holds 0x10..0x17, other entries differ in bits [11:8].
    function automatic logic [DW-1:0] lane_val(input int a, input int l);
        return DW'(((a ^ 2) << 8) | (16 + l));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_run(input int a, input int n, input bit chk_gaps);
        exp_t e;
        for (int v = 0; v < n; v++) begin
            for (int l = 0; l < N; l++) begin
                e.addr = AW'((a + v) % SZ);
                e.data = lane_val((a + v) % SZ, l);
                e.last = (v == n - 1) && (l == N - 1);
                if (!chk_gaps || (l == 0 && v == 0)) e.gap = -1;
                else if (l == 0) e.gap = RL + 1;
                else e.gap = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic issue(input int a, input int n);
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = AW'(a);
        num_vectors = (AW + 1)'(n);
        seen_valid = 1'b0;
        t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done_count"}, done_cnt, d0 + 1);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
        chk({nm, "_idle_busy"}, busy, 1'b0);
    endtask

    // Ready driver: held high unless random back-pressure is enabled.
    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        bit            hold_pending;
        logic [DW-1:0] hold_data;
        logic          hold_last;
        exp_t          e;
        hold_pending = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    chk("stall_valid", out_if.out_valid, 1'b1);
                    chk("stall_data", out_if.out_data, hold_data);
                    chk("stall_last", out_if.out_last, hold_last);
                end
                hold_pending = out_if.out_valid && !out_if.out_ready;
                hold_data = out_if.out_data;
                hold_last = out_if.out_last;
                if (out_if.out_valid && !seen_valid) begin
                    seen_valid = 1'b1;
                    first_valid_cyc = cyc;
                end
                if (out_if.out_valid && out_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h with no beat expected", out_if.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", out_if.out_data, e.data);
                        chk("beat_last", out_if.out_last, e.last);
                        chk("beat_addr", mem_address, e.addr);
                        if (e.gap >= 0) chk("beat_gap", cyc - last_hs_cyc - 1, e.gap);
                    end
                    hs_cnt++;
                    if (out_if.out_last) last_cnt++;
                    last_hs_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, d0, l0, k;
        for (int a = 0; a < SZ; a++)
            for (int l = 0; l < N; l++)
                vvrf[a][MW-1-l*DW -: DW] = lane_val(a, l);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_address", mem_address, 0);
        chk("rst_out_data", out_if.out_data, 0);
        chk("rst_out_valid", out_if.out_valid, 0);
        chk("rst_out_last", out_if.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // Single vector from vvrf[2], back-to-back lanes.
        h0 = hs_cnt; d0 = done_cnt; l0 = last_cnt;
        expect_run(2, 1, 1'b1);
        issue(2, 1);
        wait_done(d0, "single");
        chk("single_first_valid_lat", first_valid_cyc - t_start, 2 + RL);
        chk("single_beats", hs_cnt - h0, 8);
        chk("single_lasts", last_cnt - l0, 1);
        chk("single_done_lat", last_done_cyc - last_hs_cyc, 1);

        // Wrapping run 6,7,0,1 with RL+1 idle cycles between vectors.
        h0 = hs_cnt; d0 = done_cnt; l0 = last_cnt;
        expect_run(6, 4, 1'b1);
        issue(6, 4);
        wait_done(d0, "wrap");
        chk("wrap_beats", hs_cnt - h0, 32);
        chk("wrap_lasts", last_cnt - l0, 1);
        chk("wrap_done_lat", last_done_cyc - last_hs_cyc, 1);

        // Zero-length command: done and busy for exactly one cycle, no stream.
        h0 = hs_cnt; d0 = done_cnt;
        issue(4, 0);
        chk("zero_busy_t1", busy, 1'b1);
        chk("zero_done_t1", done, 1'b1);
        @(posedge clk); #1;
        chk("zero_busy_t2", busy, 1'b0);
        chk("zero_done_t2", done, 1'b0);
        chk("zero_done_lat", last_done_cyc - t_start, 1);
        chk("zero_beats", hs_cnt - h0, 0);
        chk("zero_done_count", done_cnt - d0, 1);

        // Random back-pressure over a wrapping 2-vector read.
        h0 = hs_cnt; d0 = done_cnt; l0 = last_cnt;
        rand_ready = 1'b1;
        expect_run(7, 2, 1'b0);
        issue(7, 2);
        wait_done(d0, "bp");
        rand_ready = 1'b0;
        chk("bp_beats", hs_cnt - h0, 16);
        chk("bp_lasts", last_cnt - l0, 1);

        // Reset while lane 3 of the second vector is on the bus.
        h0 = hs_cnt; d0 = done_cnt;
        expect_run(3, 2, 1'b1);
        issue(3, 2);
        k = 0;
        while (hs_cnt - h0 < 11 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reach_lane3", hs_cnt - h0, 11);
        chk("abort_lane3_data", out_if.out_data, lane_val(4, 3));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", out_if.out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);

        // Clean run after the abort.
        h0 = hs_cnt; d0 = done_cnt;
        expect_run(0, 1, 1'b1);
        issue(0, 1);
        wait_done(d0, "post_abort");
        chk("post_abort_first_valid_lat", first_valid_cyc - t_start, 2 + RL);
        chk("post_abort_beats", hs_cnt - h0, 8);

        // A start while busy is dropped; the original run is unaffected.
        h0 = hs_cnt; d0 = done_cnt;
        expect_run(3, 2, 1'b1);
        issue(3, 2);
        @(posedge clk); #1;
        chk("ignore_busy_at_restart", busy, 1'b1);
        start = 1'b1; start_addr = AW'(5); num_vectors = (AW + 1)'(1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, "ignore");
        chk("ignore_beats", hs_cnt - h0, 16);
        repeat (10) @(posedge clk);
        #1;
        chk("ignore_no_extra_beats", hs_cnt - h0, 16);
        chk("ignore_no_extra_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
